// File: rtl/y86_pipe_regs.sv
// F/D/E/M/W pipeline register bank for the Y86-64 pipelined CPU, driven by the hazard
// controller's stall/bubble signals, with retire/bubble counters and sticky halt/error flags.
module y86_pipe_regs #(
    parameter int unsigned       DATA_W   = 64,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  F_stall_i,
    input  logic                  D_stall_i,
    input  logic                  D_bubble_i,
    input  logic                  E_bubble_i,
    input  logic                  M_bubble_i,
    input  logic                  W_stall_i,
    input  logic [DATA_W-1:0]     f_predPC_i,
    input  logic [19+2*DATA_W-1:0] d_bus_i,
    input  logic [27+3*DATA_W-1:0] e_bus_i,
    input  logic [16+2*DATA_W-1:0] m_bus_i,
    input  logic [15+2*DATA_W-1:0] w_bus_i,
    output logic [DATA_W-1:0]     F_predPC_o,
    output logic [19+2*DATA_W-1:0] D_bus_o,
    output logic [27+3*DATA_W-1:0] E_bus_o,
    output logic [16+2*DATA_W-1:0] M_bus_o,
    output logic [15+2*DATA_W-1:0] W_bus_o,
    output logic                  halt_o,
    output logic                  ctrl_err_o,
    output logic [CNT_W-1:0]      retired_o,
    output logic [CNT_W-1:0]      bubbles_o
);

    localparam int unsigned D_W = 19 + 2*DATA_W;
    localparam int unsigned E_W = 27 + 3*DATA_W;
    localparam int unsigned M_W = 16 + 2*DATA_W;
    localparam int unsigned W_W = 15 + 2*DATA_W;

    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [3:0] INOP  = 4'd1;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [D_W-1:0] D_NOP = {SAOK, INOP, 4'd0, RNONE, RNONE, {(2*DATA_W){1'b0}}};
    localparam logic [E_W-1:0] E_NOP = {SAOK, INOP, 4'd0, {(3*DATA_W){1'b0}},
                                        RNONE, RNONE, RNONE, RNONE};
    localparam logic [M_W-1:0] M_NOP = {SAOK, INOP, 1'b0, {(2*DATA_W){1'b0}}, RNONE, RNONE};
    localparam logic [W_W-1:0] W_NOP = {SAOK, INOP, {(2*DATA_W){1'b0}}, RNONE, RNONE};

    logic [DATA_W-1:0] f_pc_q, f_pc_d;
    logic [D_W-1:0]    d_q, d_d;
    logic [E_W-1:0]    e_q, e_d;
    logic [M_W-1:0]    m_q, m_d;
    logic [W_W-1:0]    w_q, w_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [CNT_W-1:0]  bubbles_q, bubbles_d;

    logic       w_load;
    logic [2:0] w_in_stat;
    logic [3:0] w_in_icode;
    logic       d_bub_applied;
    logic [1:0] bub_inc;

    assign w_in_stat  = w_bus_i[W_W-1 -: 3];
    assign w_in_icode = w_bus_i[W_W-4 -: 4];

    // NOTE: every always_comb output is defaulted to its held value first, so no path
    // through the block leaves a variable unassigned and no latch can be inferred.
    always_comb begin
        f_pc_d    = f_pc_q;
        d_d       = d_q;
        e_d       = e_q;
        m_d       = m_q;
        w_d       = w_q;
        halt_d    = halt_q;
        err_d     = err_q;
        retired_d = retired_q;
        bubbles_d = bubbles_q;

        if (!F_stall_i) begin
            f_pc_d = f_predPC_i;
        end

        // Stall beats bubble on D; asserting both is a controller bug we latch for debug.
        if (D_stall_i) begin
            d_d = d_q;
        end else if (D_bubble_i) begin
            d_d = D_NOP;
        end else begin
            d_d = d_bus_i;
        end
        err_d = err_q | (D_stall_i & D_bubble_i);

        e_d = E_bubble_i ? E_NOP : e_bus_i;
        m_d = M_bubble_i ? M_NOP : m_bus_i;

        // A halted machine freezes W and both counters.
        w_load = !W_stall_i && !halt_q;
        if (w_load) begin
            w_d = w_bus_i;
            if (w_in_stat != SAOK) begin
                halt_d = 1'b1;
            end else if (w_in_icode != INOP) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end

        d_bub_applied = D_bubble_i & ~D_stall_i;
        bub_inc       = {1'b0, d_bub_applied} + {1'b0, E_bubble_i} + {1'b0, M_bubble_i};
        if (!halt_q) begin
            bubbles_d = bubbles_q + CNT_W'(bub_inc);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_pc_q    <= RESET_PC;
            d_q       <= D_NOP;
            e_q       <= E_NOP;
            m_q       <= M_NOP;
            w_q       <= W_NOP;
            halt_q    <= 1'b0;
            err_q     <= 1'b0;
            retired_q <= '0;
            bubbles_q <= '0;
        end else begin
            f_pc_q    <= f_pc_d;
            d_q       <= d_d;
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            halt_q    <= halt_d;
            err_q     <= err_d;
            retired_q <= retired_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign F_predPC_o = f_pc_q;
    assign D_bus_o    = d_q;
    assign E_bus_o    = e_q;
    assign M_bus_o    = m_q;
    assign W_bus_o    = w_q;
    assign halt_o     = halt_q;
    assign ctrl_err_o = err_q;
    assign retired_o  = retired_q;
    assign bubbles_o  = bubbles_q;

endmodule
